mipi_job_dispatcher: RTL and testbench
======================================

MIPI_JOB_DISPATCHER -- requirements
Module: mipi_job_dispatcher

Interface
REQ-001 SHALL provide parameter NUM_CORES, default 4, number of hashing cores served (power of two, 2..8).
REQ-002 SHALL provide parameter JOB_W, default 512, width of one received job block.
REQ-003 SHALL provide port rx_pixel_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port job_data  input  JOB_W  assembled job block from the MIPI receive path.
REQ-006 SHALL provide port job_valid  input  1  job_data valid; held until accepted.
REQ-007 SHALL provide port job_ready  output  1  high when the job FIFO has a free entry.
REQ-008 SHALL provide port flush  input  1  discard all queued, not-yet-issued jobs.
REQ-009 SHALL provide port core_job  output  JOB_W  shared job bus to all cores.
REQ-010 SHALL provide port core_start  output  NUM_CORES  one-hot, one-cycle start strobe.
REQ-011 SHALL provide port core_busy  input  NUM_CORES  per-core busy level.
REQ-012 SHALL provide port core_found  input  NUM_CORES  per-core result pending; held until core_ack.
REQ-013 SHALL provide port core_nonce  input  32*NUM_CORES  per-core nonce, core i at bits [32i+31:32i].
REQ-014 SHALL provide port core_ack  output  NUM_CORES  one-hot, one-cycle result-taken strobe.
REQ-015 SHALL provide port result_valid  output  1  result register holds a nonce.
REQ-016 SHALL provide port result_ready  input  1  downstream accepts result.
REQ-017 SHALL provide port result_nonce  output  32  captured nonce.
REQ-018 SHALL provide port result_core  output  log2(NUM_CORES)  index of the originating core.
REQ-019 SHALL provide port start_timeout  output  1  sticky: a started core never asserted busy.
REQ-020 SHALL provide port jobs_issued  output  16  count of completed issues, wraps 0xFFFF->0.

Function
REQ-021 Job FIFO SHALL be 2 entries deep; job_ready = (count<2); push on job_valid && job_ready.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged; data order strictly FIFO.
REQ-023 flush SHALL set count to 0 and pointers to 0 next cycle; a same-cycle push SHALL be dropped; an in-flight ISSUE/WAIT SHALL complete and then pop nothing.
REQ-024 Dispatch FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-025 IDLE->ISSUE when count>0 and any core_busy bit is 0; target = first idle core searching from (last_grant+1) mod NUM_CORES upward with wrap; target and head entry registered.
REQ-026 ISSUE SHALL last exactly one cycle, driving core_start[target]=1 and core_job=head entry; ISSUE->WAIT.
REQ-027 core_job SHALL hold the issued entry from ISSUE until the next ISSUE; core_start SHALL be 0 outside ISSUE.
REQ-028 WAIT->IDLE on core_busy[target]=1: pop FIFO, last_grant<=target, jobs_issued+1, all in that cycle.
REQ-029 WAIT SHALL time out after 16 cycles without busy: set start_timeout, no pop, last_grant<=target, ->IDLE (job retried on next core).
REQ-030 Minimum latency: job pushed at edge N with an idle core -> core_start high in cycle N+2.
REQ-031 Result arbiter SHALL capture when result register empty, or being emptied this cycle (result_valid && result_ready), and any core_found bit is 1.
REQ-032 Capture SHALL select round-robin from (last_result_core+1) with wrap, load result_nonce/result_core, set result_valid, pulse core_ack[sel] in the capture cycle.
REQ-033 result_valid SHALL stay high with stable nonce/core until result_ready; back-to-back results SHALL sustain one per cycle.
REQ-034 Result arbiter and dispatch FSM SHALL operate independently and concurrently.

Reset
REQ-035 With rst_n=0 at an edge: FSM=IDLE, FIFO count/pointers 0, job_ready=0 during reset then 1, core_start=0, core_ack=0, core_job=0, result_valid=0, result_nonce=0, result_core=0, last_grant=NUM_CORES-1, last_result_core=NUM_CORES-1, start_timeout=0, jobs_issued=0.
REQ-036 Reset mid-ISSUE/WAIT SHALL abandon the job with no further strobes.

Verification
REQ-037 After reset, all cores idle, push job A -> core_start=4'b0001 two cycles after push, core_job=A; busy[0]=1 -> jobs_issued=1.
REQ-038 Push A,B,C with core0 busy throughout -> A to core1, B to core2, C to core3; job_ready=0 while count=2.
REQ-039 Job issued to core2, busy never rises -> start_timeout=1 after 16 WAIT cycles; job reissued to core3, no pop in between.
REQ-040 core_found=4'b1010 with nonces 0x11111111/0x33333333, result_ready=1 -> results core1 then core3 on consecutive cycles, matching core_ack pulses.
REQ-041 result_ready=0 for 5 cycles with a result held -> result_valid, nonce stable; no core_ack issued to other found cores.
REQ-042 FIFO full, flush asserted with job_valid=1 -> count=0 next cycle, that job dropped, no subsequent core_start.

Source files
------------

// File: rtl/mipi_job_dispatcher.sv
// Job dispatcher for a MIPI-fed hashing array: buffers received job blocks in a 2-entry FIFO,
// issues them round-robin to idle cores, and funnels found nonces into one result register.
module mipi_job_dispatcher #(
  parameter int NUM_CORES = 4,
  parameter int JOB_W     = 512
) (
  input  logic                         rx_pixel_clk,
  input  logic                         rst_n,
  input  logic [JOB_W-1:0]             job_data,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic                         flush,
  output logic [JOB_W-1:0]             core_job,
  output logic [NUM_CORES-1:0]         core_start,
  input  logic [NUM_CORES-1:0]         core_busy,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [32*NUM_CORES-1:0]      core_nonce,
  output logic [NUM_CORES-1:0]         core_ack,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [31:0]                  result_nonce,
  output logic [$clog2(NUM_CORES)-1:0] result_core,
  output logic                         start_timeout,
  output logic [15:0]                  jobs_issued
);
  localparam int IDX_W = $clog2(NUM_CORES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // First requester strictly after 'last', wrapping; NUM_CORES is a power of two so the add wraps.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                               input logic [IDX_W-1:0]     last);
    logic [IDX_W-1:0] cand;
    logic             hit;
    rr_pick = last;
    hit     = 1'b0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = last + IDX_W'(k);
      if (!hit && req[cand]) begin
        rr_pick = cand;
        hit     = 1'b1;
      end
    end
  endfunction

  function automatic logic [NUM_CORES-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << idx;
  endfunction

  logic [JOB_W-1:0]     mem_q [2];
  logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 ready_q;
  logic                 push_s, pop_s;

  state_t               state_q;
  logic [IDX_W-1:0]     target_q, last_grant_q, grant_s;
  logic [JOB_W-1:0]     job_q;
  logic [NUM_CORES-1:0] start_q;
  logic [3:0]           wait_cnt_q;
  logic                 flushed_q, timeout_q;
  logic [15:0]          issued_q;

  logic                 rv_q, rv_d;
  logic [31:0]          nonce_q, nonce_d;
  logic [IDX_W-1:0]     rcore_q, rcore_d, last_res_q, last_res_d, sel_s;
  logic                 cap_s;
  logic [NUM_CORES-1:0] ack_s;

  // FIFO next state; a flushed-during-flight job must not pop whatever arrived after the flush.
  always_comb begin
    push_s   = job_valid && ready_q && !flush;
    pop_s    = (state_q == S_WAIT) && core_busy[target_q] && !flushed_q && !flush &&
               (count_q != 2'd0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_s) wr_ptr_d = ~wr_ptr_q;
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = ~rd_ptr_q;
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage and registered ready flag.
  always_ff @(posedge rx_pixel_clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
      mem_q[0] <= {JOB_W{1'b0}};
      mem_q[1] <= {JOB_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= (count_d != 2'd2);
      if (push_s) mem_q[wr_ptr_q] <= job_data;
    end
  end

  // Round-robin choices for the next grant and the next result capture.
  always_comb begin
    grant_s    = rr_pick(~core_busy, last_grant_q);
    sel_s      = rr_pick(core_found, last_res_q);
    cap_s      = (!rv_q || result_ready) && (|core_found);
    rv_d       = rv_q;
    nonce_d    = nonce_q;
    rcore_d    = rcore_q;
    last_res_d = last_res_q;
    ack_s      = {NUM_CORES{1'b0}};
    if (cap_s) begin
      rv_d       = 1'b1;
      nonce_d    = core_nonce[{sel_s, 5'd0} +: 32];
      rcore_d    = sel_s;
      last_res_d = sel_s;
      ack_s      = onehot(sel_s);
    end else if (rv_q && result_ready) begin
      rv_d = 1'b0;
    end else begin
      rv_d = rv_q;
    end
  end

  // Dispatch FSM with its registered strobe, job bus, timeout flag and issue counter.
  always_ff @(posedge rx_pixel_clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      target_q     <= {IDX_W{1'b0}};
      last_grant_q <= LAST_IDX;
      job_q        <= {JOB_W{1'b0}};
      start_q      <= {NUM_CORES{1'b0}};
      wait_cnt_q   <= 4'd0;
      flushed_q    <= 1'b0;
      timeout_q    <= 1'b0;
      issued_q     <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          start_q <= {NUM_CORES{1'b0}};
          if ((count_q != 2'd0) && !(&core_busy) && !flush) begin
            target_q <= grant_s;
            job_q    <= mem_q[rd_ptr_q];
            start_q  <= onehot(grant_s);
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q    <= {NUM_CORES{1'b0}};
          wait_cnt_q <= 4'd0;
          state_q    <= S_WAIT;
          if (flush) flushed_q <= 1'b1;
        end
        S_WAIT: begin
          start_q <= {NUM_CORES{1'b0}};
          if (core_busy[target_q]) begin
            last_grant_q <= target_q;
            issued_q     <= issued_q + 16'd1;
            flushed_q    <= 1'b0;
            state_q      <= S_IDLE;
          end else if (wait_cnt_q == 4'd15) begin
            // Core never acknowledged: leave the job queued so the next core retries it.
            timeout_q    <= 1'b1;
            last_grant_q <= target_q;
            flushed_q    <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
            if (flush) flushed_q <= 1'b1;
          end
        end
        default: begin
          start_q <= {NUM_CORES{1'b0}};
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Result register and round-robin pointer.
  always_ff @(posedge rx_pixel_clk) begin
    if (!rst_n) begin
      rv_q       <= 1'b0;
      nonce_q    <= 32'd0;
      rcore_q    <= {IDX_W{1'b0}};
      last_res_q <= LAST_IDX;
    end else begin
      rv_q       <= rv_d;
      nonce_q    <= nonce_d;
      rcore_q    <= rcore_d;
      last_res_q <= last_res_d;
    end
  end

  // Ack is combinational so the core drops core_found on the same edge the nonce is captured.
  assign core_ack      = ack_s;
  assign job_ready     = ready_q;
  assign core_job      = job_q;
  assign core_start    = start_q;
  assign result_valid  = rv_q;
  assign result_nonce  = nonce_q;
  assign result_core   = rcore_q;
  assign start_timeout = timeout_q;
  assign jobs_issued   = issued_q;
endmodule

// File: tb/tb_mipi_job_dispatcher.sv
// Scoreboard bench for mipi_job_dispatcher: directed stimulus pushes expected starts, acks and
// results into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_mipi_job_dispatcher;
  localparam int NC = 4;
  localparam int JW = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [JW-1:0]   job_data;
  logic            job_valid;
  logic            job_ready;
  logic            flush;
  logic [JW-1:0]   core_job;
  logic [NC-1:0]   core_start;
  logic [NC-1:0]   core_busy;
  logic [NC-1:0]   core_found;
  logic [32*NC-1:0] core_nonce;
  logic [NC-1:0]   core_ack;
  logic            result_valid;
  logic            result_ready;
  logic [31:0]     result_nonce;
  logic [1:0]      result_core;
  logic            start_timeout;
  logic [15:0]     jobs_issued;

  typedef struct { logic [3:0] oh; logic [JW-1:0] job; } start_t;
  typedef struct { logic [1:0] core; logic [31:0] nonce; } res_t;

  start_t     exp_start[$];
  res_t       exp_res[$];
  logic [3:0] exp_ack[$];
  logic [3:0] auto_mask = 4'b0000;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  mipi_job_dispatcher #(.NUM_CORES(NC), .JOB_W(JW)) dut (
    .rx_pixel_clk (clk),
    .rst_n        (rst_n),
    .job_data     (job_data),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .flush        (flush),
    .core_job     (core_job),
    .core_start   (core_start),
    .core_busy    (core_busy),
    .core_found   (core_found),
    .core_nonce   (core_nonce),
    .core_ack     (core_ack),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_nonce (result_nonce),
    .result_core  (result_core),
    .start_timeout(start_timeout),
    .jobs_issued  (jobs_issued)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [JW-1:0] mk(input logic [31:0] w);
    mk = {16{w}};
  endfunction

  // One clock: cores drop found on an ack and (if enabled) raise busy on a start.
  task automatic tick();
    logic [3:0] ack_seen, start_seen;
    @(negedge clk);
    ack_seen   = core_ack;
    start_seen = core_start;
    @(posedge clk);
    #1;
    core_found = core_found & ~ack_seen;
    core_busy  = core_busy | (start_seen & auto_mask);
  endtask

  task automatic push_job(input logic [JW-1:0] d, output int waits);
    waits     = 0;
    job_data  = d;
    job_valid = 1'b1;
    while (!job_ready && waits < 100) begin
      tick();
      waits++;
    end
    check("push_ready", job_ready, 1);
    tick();
    job_valid = 1'b0;
  endtask

  // Monitor: every DUT start, ack and result handshake is matched against the scoreboard.
  initial begin
    start_t se;
    res_t   re;
    logic [3:0] ae;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (core_start != 4'b0000) begin
          if (exp_start.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start: got %b expected none", core_start);
          end else begin
            se = exp_start.pop_front();
            check("start_onehot", core_start, se.oh);
            check("start_job", core_job[63:0], se.job[63:0]);
          end
        end
        if (core_ack != 4'b0000) begin
          if (exp_ack.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: got %b expected none", core_ack);
          end else begin
            ae = exp_ack.pop_front();
            check("ack_onehot", core_ack, ae);
          end
        end
        if (result_valid && result_ready) begin
          if (exp_res.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got core %0d expected none", result_core);
          end else begin
            re = exp_res.pop_front();
            check("result_core", result_core, re.core);
            check("result_nonce", result_nonce, re.nonce);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int n;
    rst_n = 1'b0; job_data = '0; job_valid = 1'b0; flush = 1'b0;
    core_busy = 4'b0000; core_found = 4'b0000; core_nonce = '0; result_ready = 1'b0;
    tick(); tick();
    check("rst_job_ready", job_ready, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_ack", core_ack, 0);
    check("rst_core_job", core_job[63:0], 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_nonce", result_nonce, 0);
    check("rst_result_core", result_core, 0);
    check("rst_timeout", start_timeout, 0);
    check("rst_jobs_issued", jobs_issued, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_job_ready", job_ready, 1);

    // Single job to idle array: core0 starts two edges after the push edge.
    auto_mask = 4'b0001;
    exp_start.push_back('{4'b0001, mk(32'hAAAA0001)});
    push_job(mk(32'hAAAA0001), w);
    tick();
    check("latency_start", core_start, 4'b0001);
    check("latency_job", core_job[63:0], mk(32'hAAAA0001) & 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check("start_one_cycle", core_start, 0);
    tick();
    check("jobs_after_first", jobs_issued, 1);

    // Three jobs with core0 busy: round-robin over cores 1,2,3, and a full-FIFO stall.
    auto_mask = 4'b1110;
    exp_start.push_back('{4'b0010, mk(32'hBBBB000A)});
    exp_start.push_back('{4'b0100, mk(32'hBBBB000B)});
    exp_start.push_back('{4'b1000, mk(32'hBBBB000C)});
    push_job(mk(32'hBBBB000A), w);
    push_job(mk(32'hBBBB000B), w);
    push_job(mk(32'hBBBB000C), w);
    check("full_stall", w != 0, 1);
    n = 0;
    while (jobs_issued != 16'd4 && n < 60) begin tick(); n++; end
    check("jobs_after_rr", jobs_issued, 4);

    // Core2 never goes busy: timeout after 16 WAIT cycles, then the same job goes to core3.
    rst_n = 1'b0; core_busy = 4'b0000; tick(); tick(); rst_n = 1'b1; tick();
    core_busy = 4'b0011; auto_mask = 4'b1000;
    exp_start.push_back('{4'b0100, mk(32'hDDDD0001)});
    exp_start.push_back('{4'b1000, mk(32'hDDDD0001)});
    push_job(mk(32'hDDDD0001), w);
    n = 0;
    while (!start_timeout && n < 40) begin tick(); n++; end
    check("timeout_cycles", n, 18);
    check("timeout_no_issue", jobs_issued, 0);
    n = 0;
    while (jobs_issued != 16'd1 && n < 20) begin tick(); n++; end
    check("retry_issued", jobs_issued, 1);
    check("timeout_sticky", start_timeout, 1);

    // Found on cores 1 and 3: captured on consecutive cycles in round-robin order.
    core_nonce   = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    result_ready = 1'b1;
    exp_ack.push_back(4'b0010);
    exp_ack.push_back(4'b1000);
    exp_res.push_back('{2'd1, 32'h11111111});
    exp_res.push_back('{2'd3, 32'h33333333});
    core_found = 4'b1010;
    tick();
    check("res1_core", {result_valid, result_core}, {1'b1, 2'd1});
    tick();
    check("res2_core", {result_valid, result_core}, {1'b1, 2'd3});
    tick();
    check("res_drained", result_valid, 0);

    // Backpressure: held result stays stable and no other core is acked.
    core_nonce   = {32'h33333333, 32'hC2C2C2C2, 32'h11111111, 32'hA0A0A0A0};
    result_ready = 1'b0;
    exp_ack.push_back(4'b0001);
    core_found = 4'b0101;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", result_valid, 1);
      check("hold_nonce", result_nonce, 32'hA0A0A0A0);
      tick();
    end
    exp_res.push_back('{2'd0, 32'hA0A0A0A0});
    exp_res.push_back('{2'd2, 32'hC2C2C2C2});
    exp_ack.push_back(4'b0100);
    result_ready = 1'b1;
    tick(); tick();
    check("hold_drained", result_valid, 0);

    // FIFO full with all cores busy, flush with a push pending: everything discarded.
    core_busy = 4'b1111; auto_mask = 4'b0000;
    push_job(mk(32'hEEEE0001), w);
    push_job(mk(32'hEEEE0002), w);
    check("flush_pre_full", job_ready, 0);
    job_data = mk(32'hEEEE0003); job_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; job_valid = 1'b0;
    check("flush_ready", job_ready, 1);
    core_busy = 4'b0000;
    for (int i = 0; i < 10; i++) tick();
    check("flush_no_issue", jobs_issued, 1);

    // Reset while the job is in flight: no further strobes afterwards.
    exp_start.push_back('{4'b0001, mk(32'hFFFF0001)});
    push_job(mk(32'hFFFF0001), w);
    tick(); tick();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("midrst_jobs", jobs_issued, 0);
    check("midrst_ready", job_ready, 1);

    check("sb_start_empty", exp_start.size(), 0);
    check("sb_ack_empty", exp_ack.size(), 0);
    check("sb_res_empty", exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
